// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core control path: write-back source codes,
// the HiLo sequencer state type and a saturating counter helper.
package mips_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_HILO = 2'd2;
  localparam logic [1:0] WB_PC   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Occupancy tracker for the multi-cycle HiLo unit: busy from the cycle after
// launch through the write cycle, with a one-cycle done pulse on the write.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic is_div,
  output logic md_busy,
  output logic md_done
);

  localparam int CntW = $clog2(DIV_LAT);
  // BUSY lasts LAT-1 cycles and DONE one more, so the counter starts at LAT-2.
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 2);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT - 2);

  md_state_t       state;
  md_state_t       stateNext;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cntNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (md_start) begin
          stateNext = BUSY;
          cntNext   = is_div ? DivLoad : MulLoad;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          stateNext = DONE;
        end else begin
          cntNext = cnt - CntW'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  assign md_busy = (state != IDLE);
  assign md_done = (state == DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the IF/ID and ID/EX registers: load-use and HiLo-busy stalls,
// branch flushes, HiLo unit launch, and a saturating stall-cycle counter.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_hilo_rd,
  input  logic        id_md_op,
  input  logic        id_is_div,
  input  logic        ex_rwrite,
  input  logic [1:0]  ex_wbsrc,
  input  logic [4:0]  ex_dst,
  input  logic        br_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_start,
  output logic        md_div,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  logic loadUse;
  logic hiloStall;
  logic stall;
  logic rsHit;
  logic rtHit;

  // r0 is hard-wired, so a load into it never creates a dependency.
  assign rsHit     = id_use_rs && (id_rs == ex_dst);
  assign rtHit     = id_use_rt && (id_rt == ex_dst);
  assign loadUse   = id_valid && ex_rwrite && (ex_wbsrc == WB_MEM) &&
                     (ex_dst != 5'd0) && (rsHit || rtHit);
  assign hiloStall = id_valid && (id_hilo_rd || id_md_op) && md_busy;
  assign stall     = (loadUse || hiloStall) && !br_taken;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign md_start = id_valid && id_md_op && !stall && !br_taken;
  assign md_div   = md_start && id_is_div;

  // A branch does not cancel an op already in flight; it only squashes ID.
  md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_sequencer (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .is_div   (id_is_div),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (stall) begin
      stall_cnt <= satInc16(stall_cnt);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and multiply/divide scheduler for the modified MIPS core. It sits beside the IF/ID and ID/EX pipeline registers and produces their enable, flush and bubble controls. It detects load-use hazards and branch redirects, and sequences the multi-cycle HiLo (mult/div) unit. While that unit is busy, it holds any dependent instruction in ID.

## Interface
Parameters:
- MUL_LAT, 4: cycles from `md_start` to HiLo result valid for mult.
- DIV_LAT, 16: the same latency for div. Must be ≥ MUL_LAT and ≥ 2.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- id_valid, in, 1: ID holds a real instruction.
- id_rs / id_rt, in, 5 each: ID source register numbers.
- id_use_rs / id_use_rt, in, 1 each: the instruction actually reads that source.
- id_hilo_rd, in, 1: ID instruction is mfhi/mflo.
- id_md_op, in, 1: ID instruction is mult/div (a HiLo write).
- id_is_div, in, 1: qualifies `id_md_op`; 1 = div.
- ex_rwrite, in, 1: ID/EX register-write flag.
- ex_wbsrc, in, 2: ID/EX write-back source.
- ex_dst, in, 5: ID/EX destination register.
- br_taken, in, 1: EX resolved a taken branch/jump.
- pc_en, out, 1: PC update enable.
- ifid_en, out, 1: IF/ID load enable.
- ifid_flush, out, 1: clear IF/ID to NOP.
- idex_bubble, out, 1: force ID/EX control fields (RWrite, MWrite, HiLoWrite, Float) to 0.
- md_start, out, 1: launch the HiLo unit this cycle.
- md_div, out, 1: operation select accompanying `md_start`.
- md_busy, out, 1: HiLo unit occupied.
- md_done, out, 1: one-cycle pulse; the HiLo write happens this cycle.
- stall_cnt, out, 16: saturating count of stall cycles.

## Operation
Conditions:
- Load-use: `load_use = id_valid & ex_rwrite & ex_wbsrc==WB_MEM & ex_dst!=0 & ((id_use_rs & id_rs==ex_dst) | (id_use_rt & id_rt==ex_dst))`.
- HiLo: `hilo_stall = id_valid & (id_hilo_rd | id_md_op) & md_busy`.
- `stall = (load_use | hilo_stall) & ~br_taken`.

Priority: `br_taken` > stall > normal.
- br_taken: `ifid_flush=1`, `idex_bubble=1`, `pc_en=1`, `ifid_en=1`, `md_start=0`.
- stall: `pc_en=0`, `ifid_en=0`, `idex_bubble=1`.
- normal: `pc_en=ifid_en=1`, `idex_bubble=0`.

`md_start = id_valid & id_md_op & ~stall & ~br_taken`. `md_div = id_is_div` when `md_start` is 1, else 0.

FSM states are IDLE, BUSY and DONE. A down-counter `cnt` is `$clog2(DIV_LAT)` bits wide.
- IDLE → BUSY on `md_start`. Load `cnt` = LAT−2, where LAT is chosen by `id_is_div`.
- BUSY: when `cnt`==0, go to DONE; otherwise decrement.
- DONE → IDLE unconditionally. `md_start` cannot occur here, because `md_busy` stalls any `id_md_op`.
- `md_busy` = state≠IDLE. `md_done` = state==DONE.

`stall_cnt` increments on every cycle where `stall`=1 and saturates at 16'hFFFF.

## Timing
- All hazard outputs are combinational from current inputs and state. FSM, `cnt` and `stall_cnt` are registered.
- `md_start` in cycle T → `md_busy` is 1 for cycles T+1 through T+LAT, and `md_done` is 1 in T+LAT only.
- An mfhi/mflo or mult/div in ID stalls through T+LAT and proceeds in T+LAT+1.
- Load-use stall lasts exactly 1 cycle, because the bubble clears `ex_rwrite` on the next edge.
- `br_taken` during an MD operation: the FSM continues, since the op is older than the branch. Only the ID instruction is discarded.
- `ex_dst`==0 never causes a stall.
- Reset values: state IDLE, `cnt`=0, `stall_cnt`=0. Therefore `md_busy=0`, `md_done=0`, `md_start=0`, `stall_cnt=0`. The combinational outputs are then `pc_en=ifid_en=1` and `idex_bubble=ifid_flush=0`, provided `br_taken`=0.
- `rst` mid-operation: the in-flight MD op is abandoned and no `md_done` pulse is produced. `rst` dominates all inputs on that edge.

## Structure
- Shared package `mips_pkg` holds the write-back codes WB_ALU=2'd0, WB_MEM=2'd1, WB_HILO=2'd2, WB_PC=2'd3, plus the FSM state enum `md_state_t`.
- One sub-module, `md_sequencer`, contains the FSM, `cnt`, `md_busy` and `md_done`.
- The hazard logic and `stall_cnt` live in `hazard_ctrl`.

## Test plan
- Load-use: EX is lw with dst=5 and `ex_rwrite`=1; ID reads rs=5 → one cycle of `pc_en=0`, `ifid_en=0`, `idex_bubble=1`, then normal; `stall_cnt`=1.
- Mult then mflo: `md_start` at T with MUL_LAT=4 → `md_busy` 1 for T+1..T+4, `md_done` at T+4; mflo stalls 4 cycles and issues at T+5.
- Div back-to-back: div, then div next → second `md_start` occurs exactly at T+17; `md_div`=1 both times.
- Branch during stall: load-use and `br_taken` in the same cycle → `ifid_flush=1`, `idex_bubble=1`, `pc_en=1`; `stall_cnt` unchanged.
- rst at T+2 of a div → next cycle `md_busy=0`, and no `md_done` pulse ever follows.
- Saturation: force 70000 stall cycles → `stall_cnt`=16'hFFFF.
